vx_mem_tag_remap: RTL

//  Sits directly upstream of the AXI adapter on the request path and downstream on the response path.

---
 rtl/vx_mem_tag_remap_if.sv | 32 +++
 rtl/vx_mem_tag_remap.sv | 110 +++++++++++
 2 files changed

// File: rtl/vx_mem_tag_remap_if.sv
// Memory request/response bus shared by the Vortex side and the AXI-adapter side
// of the tag remapper. The master issues requests and consumes responses; the
// slave accepts requests and produces responses. Only TAG_WIDTH differs between
// the two sides.
interface vx_mem_tag_remap_if #(
   parameter int DATA_WIDTH = 512,
   parameter int ADDR_WIDTH = 26,
   parameter int TAG_WIDTH  = 16
);
   logic                    req_valid;
   logic                    req_rw;
   logic [DATA_WIDTH/8-1:0] req_byteen;
   logic [ADDR_WIDTH-1:0]   req_addr;
   logic [DATA_WIDTH-1:0]   req_data;
   logic [TAG_WIDTH-1:0]    req_tag;
   logic                    req_ready;

   logic                    rsp_valid;
   logic [DATA_WIDTH-1:0]   rsp_data;
   logic [TAG_WIDTH-1:0]    rsp_tag;
   logic                    rsp_ready;

   modport master (
      output req_valid, req_rw, req_byteen, req_addr, req_data, req_tag, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_tag
   );

   modport slave (
      input  req_valid, req_rw, req_byteen, req_addr, req_data, req_tag, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_tag
   );
endinterface

// File: rtl/vx_mem_tag_remap.sv
// Vortex-to-AXI tag remapper. Read requests trade their wide Vortex tag for the
// lowest free compact ID; the original tag is parked in a table and put back on
// the matching read response. Reads stall once every ID is in flight; writes
// pass straight through with ID 0 and never touch the bookkeeping.
module vx_mem_tag_remap #(
   parameter int DATA_WIDTH    = 512,
   parameter int ADDR_WIDTH    = 26,
   parameter int TAG_IN_WIDTH  = 16,
   parameter int MAX_PENDING   = 16,
   parameter int TAG_OUT_WIDTH = $clog2(MAX_PENDING)
) (
   input  logic                     clk,
   input  logic                     reset,
   vx_mem_tag_remap_if.slave        in_if,
   vx_mem_tag_remap_if.master       out_if,
   output logic [TAG_OUT_WIDTH:0]   pending_count,
   output logic                     full,
   output logic                     empty
);

   localparam int CW = TAG_OUT_WIDTH + 1;

   logic [MAX_PENDING-1:0]  busy_q, busy_d;
   logic [TAG_IN_WIDTH-1:0] tagTable_q [MAX_PENDING];
   logic [CW-1:0]           pendingCount_q, pendingCount_d;

   logic [TAG_OUT_WIDTH-1:0] allocId;
   logic                     canIssue;
   logic                     readFire;
   logic                     rspFire;

   // Lowest-index free ID; scanning downward lets the lowest free slot win.
   always_comb begin
      allocId = '0;
      for (int i = MAX_PENDING - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            allocId = TAG_OUT_WIDTH'(i);
         end
      end
   end

   // Occupancy flags come from the counter so they never depend on the busy scan.
   assign full          = (pendingCount_q == CW'(MAX_PENDING));
   assign empty         = (pendingCount_q == '0);
   assign pending_count = pendingCount_q;

   // Request path: writes always flow, reads only while an ID is available.
   assign canIssue          = in_if.req_rw || !full;
   assign out_if.req_valid  = in_if.req_valid && canIssue;
   assign in_if.req_ready   = out_if.req_ready && canIssue;
   assign out_if.req_rw     = in_if.req_rw;
   assign out_if.req_byteen = in_if.req_byteen;
   assign out_if.req_addr   = in_if.req_addr;
   assign out_if.req_data   = in_if.req_data;
   assign out_if.req_tag    = in_if.req_rw ? '0 : allocId;

   assign readFire = in_if.req_valid && in_if.req_ready && !in_if.req_rw;

   // Response path: straight through, with the original tag looked up by ID.
   assign in_if.rsp_valid  = out_if.rsp_valid;
   assign out_if.rsp_ready = in_if.rsp_ready;
   assign in_if.rsp_data   = out_if.rsp_data;
   assign in_if.rsp_tag    = tagTable_q[out_if.rsp_tag];

   assign rspFire = out_if.rsp_valid && in_if.rsp_ready;

   // Next-state busy map and counter; release and allocate never collide on one ID.
   always_comb begin
      busy_d = busy_q;
      if (rspFire) begin
         busy_d[out_if.rsp_tag] = 1'b0;
      end
      if (readFire) begin
         busy_d[allocId] = 1'b1;
      end
      pendingCount_d = pendingCount_q + CW'(readFire) - CW'(rspFire);
   end

   // Busy map and counter; reset frees every ID at once.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q         <= '0;
         pendingCount_q <= '0;
      end else begin
         busy_q         <= busy_d;
         pendingCount_q <= pendingCount_d;
      end
   end

   // Parked Vortex tags; contents are meaningless until an ID is allocated.
   always_ff @(posedge clk) begin
      if (readFire) begin
         tagTable_q[allocId] <= in_if.req_tag;
      end
   end

   // Guard against responses for IDs that were never handed out and counter misuse.
   assertRspBusy: assert property (@(posedge clk) disable iff (reset)
      rspFire |-> busy_q[out_if.rsp_tag])
      else $error("vx_mem_tag_remap: response on idle ID %0d", out_if.rsp_tag);

   assertNoOverflow: assert property (@(posedge clk) disable iff (reset)
      (readFire && !rspFire) |-> (pendingCount_q != CW'(MAX_PENDING)))
      else $error("vx_mem_tag_remap: pending count overflow");

   assertNoUnderflow: assert property (@(posedge clk) disable iff (reset)
      (rspFire && !readFire) |-> (pendingCount_q != '0))
      else $error("vx_mem_tag_remap: pending count underflow");

endmodule
